regfile_mp: RTL and testbench

REGFILE_MP -- requirements
Module: regfile_mp

---
 rtl/regfile_mp.sv | 116 +++++++++++
 tb/tb_regfile_mp.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// Multi-read-port register file with byte-enabled write, same-cycle write bypass,
// a preloaded entry at reset and a sequential clear engine that zeroes entries 1..DEPTH-1.
module regfile_mp #(
  parameter int DW      = 32,
  parameter int AW      = 5,
  parameter int NRD     = 2,
  parameter int PRE_IDX = 1,
  parameter int OBS_IDX = 2
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic [NRD*AW-1:0] raddr,
  output logic [NRD*DW-1:0] rdata,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DW-1:0]     wdata,
  input  logic [DW/8-1:0]   wbe,
  input  logic              clr_req,
  output logic              busy,
  input  logic [DW-1:0]     pre_val,
  output logic [DW-1:0]     obs,
  output logic              dbg_state
);

  localparam int DEPTH = 2**AW;
  localparam int NB    = DW/8;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_CLEAR = 1'b1;

  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH-1);
  localparam logic [AW-1:0] FIRST_IDX = AW'(1);

  logic          state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];
  logic [DW-1:0] view  [DEPTH];
  logic          wr_act;
  logic [DW-1:0] wr_merged;

  assign busy      = (state_q == ST_CLEAR);
  assign dbg_state = state_q;

  // A write is dropped entirely while clearing or in reset, so it never bypasses either.
  assign wr_act = we && !busy && nrst && (waddr != '0);

  always_comb begin
    wr_merged = mem_q[waddr];
    for (int i = 0; i < NB; i++) begin
      if (wbe[i]) wr_merged[i*8 +: 8] = wdata[i*8 +: 8];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (clr_req) begin
          state_d = ST_CLEAR;
          cnt_d   = FIRST_IDX;
        end
      end
      ST_CLEAR: begin
        if (cnt_q == LAST_IDX) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + FIRST_IDX;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) mem_d[i] = mem_q[i];
    if (wr_act) mem_d[waddr] = wr_merged;
    if (state_q == ST_CLEAR && cnt_q != '0) mem_d[cnt_q] = '0;
    mem_d[0] = '0;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= (i == PRE_IDX) ? pre_val : '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

  // While reset is held the readable contents follow pre_val directly, even between edges.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      if (nrst) view[i] = mem_q[i];
      else      view[i] = (i == PRE_IDX) ? pre_val : '0;
    end
    view[0] = '0;
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] ra;
    assign ra = raddr[k*AW +: AW];
    assign rdata[k*DW +: DW] = (wr_act && ra == waddr) ? wr_merged : view[ra];
  end

  assign obs = view[OBS_IDX];

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: reset checks, a table of write/bypass vectors, clear corner
// sequences and a randomized run checked against an array-based reference model.
module tb_regfile_mp;

  logic        clk;
  logic        nrst;
  logic [9:0]  raddr;
  logic [63:0] rdata;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [3:0]  wbe;
  logic        clr_req;
  logic        busy;
  logic [31:0] pre_val;
  logic [31:0] obs;
  logic        dbg_state;

  int tests_run;
  int tests_failed;

  regfile_mp dut (
    .clk(clk), .nrst(nrst), .raddr(raddr), .rdata(rdata), .we(we), .waddr(waddr),
    .wdata(wdata), .wbe(wbe), .clr_req(clr_req), .busy(busy), .pre_val(pre_val),
    .obs(obs), .dbg_state(dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain array plus a "clear in progress" flag and next index.
  logic [31:0] m_mem [32];
  bit          m_busy;
  int          m_ptr;

  logic [31:0] s_rd0, s_rd1, s_obs;
  logic        s_busy;

  typedef struct {
    logic        w;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [3:0]  be;
    logic [4:0]  a0;
    logic [4:0]  a1;
    logic [31:0] e_rd0;
    logic [31:0] e_rd1;
    logic [31:0] e_obs;
  } vec_t;

  vec_t vecs [7];

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (be[i]) r[i*8 +: 8] = wd[i*8 +: 8];
    return r;
  endfunction

  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (!m_busy && we && waddr != 5'd0 && a == waddr) return merge(m_mem[a], wdata, wbe);
    return m_mem[a];
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 32; i++) m_mem[i] = 32'd0;
    m_mem[1] = pre_val;
    m_busy = 0;
    m_ptr  = 0;
  endtask

  task automatic m_step(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                        input logic [3:0] be, input logic c);
    if (m_busy) begin
      m_mem[m_ptr] = 32'd0;
      if (m_ptr == 31) m_busy = 0;
      else m_ptr++;
    end else begin
      if (w && wa != 5'd0) m_mem[wa] = merge(m_mem[wa], wd, be);
      if (c) begin
        m_busy = 1;
        m_ptr  = 1;
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_outputs();
    check("rd0", rdata[31:0], exp_rd(raddr[4:0]));
    check("rd1", rdata[63:32], exp_rd(raddr[9:5]));
    check("obs", obs, m_mem[2]);
    check("busy", {31'd0, busy}, {31'd0, m_busy});
    check("dbg_state", {31'd0, dbg_state}, {31'd0, m_busy});
  endtask

  task automatic cycle(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [3:0] be, input logic c, input logic [4:0] a0,
                       input logic [4:0] a1);
    @(negedge clk);
    we = w; waddr = wa; wdata = wd; wbe = be; clr_req = c; raddr = {a1, a0};
    #1;
    check_outputs();
    s_rd0 = rdata[31:0]; s_rd1 = rdata[63:32]; s_obs = obs; s_busy = busy;
    @(posedge clk);
    m_step(w, wa, wd, be, c);
  endtask

  task automatic idle_inputs();
    we = 0; waddr = 0; wdata = 0; wbe = 0; clr_req = 0;
  endtask

  task automatic fill(input bit rnd);
    for (int i = 1; i < 32; i++)
      cycle(1'b1, 5'(i), rnd ? $urandom : 32'(i), 4'hF, 1'b0, 5'(i), 5'(i - 1));
  endtask

  task automatic run_clear(input string name, input bit poke_writes);
    int cnt;
    cnt = 0;
    for (int n = 0; n < 40; n++) begin
      cycle(poke_writes && n < 12, 5'd3, $urandom, 4'hF, poke_writes && n == 15,
            5'd3, 5'd31);
      if (s_busy) cnt++;
    end
    check(name, cnt, 31);
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    nrst = 0;
    pre_val = 32'h5;
    raddr = {5'd2, 5'd1};
    idle_inputs();
    #1;
    m_reset();
    check("rst_rd_pre", rdata[31:0], 32'h0000_0005);
    check("rst_obs", obs, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    repeat (3) @(negedge clk);
    nrst = 1;

    vecs[0] = '{1'b1, 5'd2,  32'hAABBCCDD, 4'b0101, 5'd2, 5'd1,  32'h00BB00DD, 32'h5,        32'h0};
    vecs[1] = '{1'b1, 5'd0,  32'hFFFFFFFF, 4'b1111, 5'd0, 5'd2,  32'h0,        32'h00BB00DD, 32'h00BB00DD};
    vecs[2] = '{1'b1, 5'd2,  32'h11223344, 4'b1010, 5'd2, 5'd2,  32'h11BB33DD, 32'h11BB33DD, 32'h00BB00DD};
    vecs[3] = '{1'b0, 5'd2,  32'h0,        4'b1111, 5'd2, 5'd0,  32'h11BB33DD, 32'h0,        32'h11BB33DD};
    vecs[4] = '{1'b1, 5'd1,  32'hCAFEBABE, 4'b0000, 5'd1, 5'd31, 32'h5,        32'h0,        32'h11BB33DD};
    vecs[5] = '{1'b1, 5'd31, 32'hDEADBEEF, 4'b1111, 5'd31, 5'd1, 32'hDEADBEEF, 32'h5,        32'h11BB33DD};
    vecs[6] = '{1'b0, 5'd0,  32'h0,        4'b0000, 5'd31, 5'd2, 32'hDEADBEEF, 32'h11BB33DD, 32'h11BB33DD};
    for (int i = 0; i < 7; i++) begin
      cycle(vecs[i].w, vecs[i].wa, vecs[i].wd, vecs[i].be, 1'b0, vecs[i].a0, vecs[i].a1);
      check($sformatf("vec%0d_rd0", i), s_rd0, vecs[i].e_rd0);
      check($sformatf("vec%0d_rd1", i), s_rd1, vecs[i].e_rd1);
      check($sformatf("vec%0d_obs", i), s_obs, vecs[i].e_obs);
    end

    // Index-valued fill, then a full clear watched on entry 31.
    fill(0);
    cycle(1'b0, 5'd0, 32'd0, 4'h0, 1'b1, 5'd31, 5'd30);
    check("pre_clear_31", s_rd0, 32'd31);
    run_clear("busy_len", 0);
    for (int j = 0; j < 16; j++) begin
      cycle(1'b0, 5'd0, 32'd0, 4'h0, 1'b0, 5'(2*j), 5'(2*j + 1));
      check("clr_zero_a", s_rd0, 32'd0);
      check("clr_zero_b", s_rd1, 32'd0);
    end

    // Write coinciding with the clear request, writes and a re-request during clear.
    fill(1);
    cycle(1'b1, 5'd3, 32'h1357_9BDF, 4'hF, 1'b1, 5'd3, 5'd4);
    check("wr_with_clr_bypass", s_rd0, 32'h1357_9BDF);
    run_clear("busy_len_ignored", 1);
    cycle(1'b0, 5'd0, 32'd0, 4'h0, 1'b0, 5'd3, 5'd1);
    check("entry3_zero", s_rd0, 32'd0);

    // Reset during the clear aborts it at once.
    fill(1);
    cycle(1'b0, 5'd0, 32'd0, 4'h0, 1'b1, 5'd1, 5'd2);
    for (int n = 0; n < 9; n++) cycle(1'b0, 5'd0, 32'd0, 4'h0, 1'b0, 5'd31, 5'd5);
    @(negedge clk);
    pre_val = 32'h1234_5678;
    idle_inputs();
    nrst = 0;
    #1;
    m_reset();
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_obs", obs, 32'd0);
    for (int a = 0; a < 32; a++) begin
      raddr = {5'(a), 5'(a)};
      #1;
      check("abort_entry", rdata[31:0], (a == 1) ? 32'h1234_5678 : 32'd0);
    end
    @(negedge clk);
    nrst = 1;
    cycle(1'b0, 5'd0, 32'd0, 4'h0, 1'b0, 5'd1, 5'd2);
    check("post_abort_pre", s_rd0, 32'h1234_5678);

    for (int n = 0; n < 400; n++) begin
      logic [4:0] wa;
      wa = 5'($urandom_range(0, 31));
      cycle(1'($urandom_range(0, 1)), wa, $urandom, 4'($urandom_range(0, 15)),
            $urandom_range(0, 49) == 0,
            $urandom_range(0, 1) ? wa : 5'($urandom_range(0, 31)),
            5'($urandom_range(0, 31)));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
